// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corr_pkg
// Purpose  : Shared types and width helpers for the multi-lag correlator.
// Revision : 1.0 - initial release
// ============================================================================
package corr_pkg;

  // Control FSM states
  typedef enum logic [0:0] {
    CORR_IDLE = 1'b0,
    CORR_RUN  = 1'b1
  } corr_state_e;

  // Signed score width: one bit wider than the match counter
  function automatic int score_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // Lag index width
  function automatic int lag_w(input int lags);
    return $clog2(lags);
  endfunction

endpackage
`default_nettype wire

// File: rtl/corr_lag_cell.sv
`default_nettype none
// ============================================================================
// Module   : corr_lag_cell
// Purpose  : One correlator lag: compares the sample with its delayed code
//            tap and accumulates matches. o_snap is the count including the
//            current compare, so the top can snapshot it on the final strobe.
// Revision : 1.0 - initial release
// ============================================================================
module corr_lag_cell #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sig,
  input  logic             i_code,
  output logic [CNT_W-1:0] o_snap
);

  logic [CNT_W-1:0] r_acc;
  logic             w_match;

  assign w_match = (i_sig == i_code);
  assign o_snap  = r_acc + CNT_W'(w_match);

  // Accumulate matches on each strobe; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_snap;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_lag_correlator.sv
`default_nettype none
// ============================================================================
// Module   : multi_lag_correlator
// Purpose  : Correlates a 1-bit sample stream against LAGS delayed copies of
//            a reference code over a programmable period, snapshots results
//            into a bank drained over valid/ready.
//            Build option CORR_PEAK_EN: adds the running peak search; when
//            undefined the peak outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module multi_lag_correlator
  import corr_pkg::*;
#(
  parameter int LAGS     = 8,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sig,
  input  logic                      code,
  input  logic                      sample_en,
  input  logic                      start,
  input  logic                      stop,
  input  logic [PERIOD_W-1:0]       period,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lag_w(LAGS)-1:0]    out_lag,
  output logic [CNT_W-1:0]          out_match,
  output logic [score_w(CNT_W)-1:0] out_score,
  output logic                      out_last,
  output logic                      overrun,
  output logic                      peak_valid,
  output logic [lag_w(LAGS)-1:0]    peak_lag,
  output logic [score_w(CNT_W)-1:0] peak_score
);

  localparam int c_LAG_W   = lag_w(LAGS);
  localparam int c_SCORE_W = score_w(CNT_W);
  localparam logic [c_LAG_W-1:0] c_LAST_LAG = c_LAG_W'(LAGS - 1);

  corr_state_e          r_state;
  logic [PERIOD_W-1:0]  r_period;
  logic [PERIOD_W-1:0]  r_cnt;
  logic [PERIOD_W-1:0]  w_cnt_inc;
  logic [LAGS-2:0]      r_code_dly;
  logic [LAGS-1:0]      w_code_tap;
  logic [CNT_W-1:0]     w_snap [LAGS];
  logic                 w_start_go;
  logic                 w_run_strobe;
  logic                 w_period_end;
  logic                 w_acc_clr;

  logic [CNT_W-1:0]     r_bank [LAGS];
  logic [PERIOD_W-1:0]  r_bank_period;
  logic                 r_full;
  logic [c_LAG_W-1:0]   r_rd_idx;
  logic                 r_overrun;
  logic                 w_accept;
  logic                 w_last_accept;
  logic                 w_bank_free;

  // Tap 0 is the live code; tap k is the code k strobes ago
  assign w_code_tap = {r_code_dly, code};

  // stop beats start; start with a zero period is ignored
  assign w_start_go   = start && !stop && (period != '0);
  assign w_run_strobe = (r_state == CORR_RUN) && sample_en && !stop && !w_start_go;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_period_end = w_run_strobe && (w_cnt_inc == r_period);
  assign w_acc_clr    = stop || w_start_go || w_period_end;

  // Code delay line shifts on every strobe regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_dly <= '0;
    end else if (sample_en) begin
      r_code_dly <= w_code_tap[LAGS-2:0];
    end
  end

  // Control FSM, latched period and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CORR_IDLE;
      r_period <= '0;
      r_cnt    <= '0;
    end else begin
      if (stop) begin
        r_state <= CORR_IDLE;
      end else if (w_start_go) begin
        r_state  <= CORR_RUN;
        r_period <= period;
      end
      if (w_acc_clr) begin
        r_cnt <= '0;
      end else if (w_run_strobe) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  generate
    for (genvar k = 0; k < LAGS; k++) begin : g_lag
      corr_lag_cell #(
        .CNT_W (CNT_W)
      ) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_acc_clr),
        .i_en   (w_run_strobe),
        .i_sig  (sig),
        .i_code (w_code_tap[k]),
        .o_snap (w_snap[k])
      );
    end
  endgenerate

  assign w_accept      = r_full && out_ready;
  assign w_last_accept = w_accept && (r_rd_idx == c_LAST_LAG);
  // The bank can be refilled in the same cycle its last beat leaves
  assign w_bank_free   = !r_full || w_last_accept;

  // Bank occupancy, drain pointer and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full        <= 1'b0;
      r_rd_idx      <= '0;
      r_bank_period <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_period_end && w_bank_free) begin
        r_full        <= 1'b1;
        r_rd_idx      <= '0;
        r_bank_period <= r_period;
      end else if (w_accept) begin
        if (w_last_accept) begin
          r_full <= 1'b0;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
      if (w_start_go) begin
        r_overrun <= 1'b0;
      end else if (w_period_end && !w_bank_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Snapshot final per-lag counts into the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAGS; k++) r_bank[k] <= '0;
    end else if (w_period_end && w_bank_free) begin
      for (int k = 0; k < LAGS; k++) r_bank[k] <= w_snap[k];
    end
  end

  assign out_valid = r_full;
  assign out_lag   = r_rd_idx;
  assign out_match = r_bank[r_rd_idx];
  assign out_last  = r_full && (r_rd_idx == c_LAST_LAG);
  assign overrun   = r_overrun;
  // Score uses the period the bank was filled with, not the live one
  assign out_score = {out_match, 1'b0} - c_SCORE_W'(r_bank_period);

`ifdef CORR_PEAK_EN
  logic [c_LAG_W-1:0]   r_best_lag;
  logic [c_SCORE_W-1:0] r_best_score;
  logic [c_LAG_W-1:0]   w_cand_lag;
  logic [c_SCORE_W-1:0] w_cand_score;
  logic                 r_peak_valid;
  logic [c_LAG_W-1:0]   r_peak_lag;
  logic [c_SCORE_W-1:0] r_peak_score;

  // Lag 0 seeds the search; strict greater-than keeps the lowest lag on ties
  always_comb begin
    w_cand_lag   = r_best_lag;
    w_cand_score = r_best_score;
    if ((r_rd_idx == '0) || ($signed(out_score) > $signed(r_best_score))) begin
      w_cand_lag   = r_rd_idx;
      w_cand_score = out_score;
    end
  end

  // Running maximum over accepted beats, published after the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_lag   <= '0;
      r_best_score <= '0;
      r_peak_valid <= 1'b0;
      r_peak_lag   <= '0;
      r_peak_score <= '0;
    end else begin
      r_peak_valid <= w_last_accept;
      if (w_accept) begin
        r_best_lag   <= w_cand_lag;
        r_best_score <= w_cand_score;
      end
      if (w_last_accept) begin
        r_peak_lag   <= w_cand_lag;
        r_peak_score <= w_cand_score;
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_lag   = r_peak_lag;
  assign peak_score = r_peak_score;
`else
  assign peak_valid = 1'b0;
  assign peak_lag   = '0;
  assign peak_score = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_lag_correlator.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_lag_correlator
// Purpose  : Self-checking bench for multi_lag_correlator (LAGS=4, period 8).
//            A behavioural model pushes expected beats to a queue as strobes
//            are driven; a monitor pops and compares accepted beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_lag_correlator;

  localparam int LAGS     = 4;
  localparam int PERIOD_W = 16;
  localparam int CNT_W    = 32;

  typedef struct {
    logic [1:0]  lag;
    logic [31:0] match;
    logic [32:0] score;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  lag;
    logic [32:0] score;
  } peak_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sig = 1'b0;
  logic                code = 1'b0;
  logic                sample_en = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [1:0]          out_lag;
  logic [CNT_W-1:0]    out_match;
  logic [CNT_W:0]      out_score;
  logic                out_last;
  logic                overrun;
  logic                peak_valid;
  logic [1:0]          peak_lag;
  logic [CNT_W:0]      peak_score;

  multi_lag_correlator #(
    .LAGS     (LAGS),
    .PERIOD_W (PERIOD_W),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (sig),
    .code       (code),
    .sample_en  (sample_en),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lag    (out_lag),
    .out_match  (out_match),
    .out_score  (out_score),
    .out_last   (out_last),
    .overrun    (overrun),
    .peak_valid (peak_valid),
    .peak_lag   (peak_lag),
    .peak_score (peak_score)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  peak_t pk_q[$];

  // Model state
  bit    m_run = 1'b0;
  bit    m_push = 1'b1;
  int    m_period = 0;
  int    m_cnt = 0;
  int    m_acc[LAGS];
  bit    m_hist[LAGS-1];
  logic [3:0] lfsr = 4'b1001;
  bit    d1 = 1'b0;
  bit    d2 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_result();
    int best;
    int best_lag;
    beat_t b;
    peak_t p;
    best = 0;
    best_lag = 0;
    for (int k = 0; k < LAGS; k++) begin
      int sc;
      sc = 2 * m_acc[k] - m_period;
      b.lag   = 2'(k);
      b.match = 32'(m_acc[k]);
      b.score = 33'(sc);
      b.last  = (k == LAGS - 1);
      exp_q.push_back(b);
      if (k == 0 || sc > best) begin
        best = sc;
        best_lag = k;
      end
    end
    p.lag   = 2'(best_lag);
    p.score = 33'(best);
    pk_q.push_back(p);
  endtask

  task automatic strobe(input bit s, input bit c);
    bit tap[LAGS];
    tap[0] = c;
    for (int k = 1; k < LAGS; k++) tap[k] = m_hist[k-1];
    sig = s;
    code = c;
    sample_en = 1'b1;
    if (m_run) begin
      m_cnt++;
      for (int k = 0; k < LAGS; k++) m_acc[k] += (s == tap[k]) ? 1 : 0;
      if (m_cnt == m_period) begin
        if (m_push) push_result();
        m_cnt = 0;
        for (int k = 0; k < LAGS; k++) m_acc[k] = 0;
      end
    end
    for (int k = LAGS - 2; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = c;
    tick();
    sample_en = 1'b0;
  endtask

  // PN code with sig equal to the code two strobes earlier
  task automatic pn_strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bit c;
      c = lfsr[0];
      strobe(d2, c);
      d2 = d1;
      d1 = c;
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      idle(gap);
    end
  endtask

  task automatic do_start(input int p);
    start = 1'b1;
    period = PERIOD_W'(p);
    if (p != 0) begin
      m_run = 1'b1;
      m_period = p;
      m_cnt = 0;
      for (int k = 0; k < LAGS; k++) m_acc[k] = 0;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    m_run = 1'b0;
    tick();
    stop = 1'b0;
  endtask

  // Monitor: compare accepted beats and the peak pulse that follows
  bit pend_peak = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_peak = 1'b0;
    end else begin
      if (pend_peak) begin
        peak_t p;
        pend_peak = 1'b0;
        check_eq("peak_valid", 64'(peak_valid), 64'd1);
        if (pk_q.size() > 0) begin
          p = pk_q.pop_front();
          check_eq("peak_lag", 64'(peak_lag), 64'(p.lag));
          check_eq("peak_score", 64'(peak_score), 64'(p.score));
        end
      end else if (peak_valid) begin
        check_eq("peak_valid_spurious", 64'(peak_valid), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 64'(out_valid), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check_eq("beat_lag", 64'(out_lag), 64'(e.lag));
          check_eq("beat_match", 64'(out_match), 64'(e.match));
          check_eq("beat_score", 64'(out_score), 64'(e.score));
          check_eq("beat_last", 64'(out_last), 64'(e.last));
          if (e.last) begin
`ifdef CORR_PEAK_EN
            pend_peak = 1'b1;
`else
            check_eq("peak_tied_valid", 64'(peak_valid), 64'd0);
            check_eq("peak_tied_lag", 64'(peak_lag), 64'd0);
            check_eq("peak_tied_score", 64'(peak_score), 64'd0);
`endif
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < LAGS; k++) m_acc[k] = 0;
    for (int k = 0; k < LAGS - 1; k++) m_hist[k] = 1'b0;

    // Reset state
    idle(3);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_lag", 64'(out_lag), 64'd0);
    check_eq("rst_out_match", 64'(out_match), 64'd0);
    check_eq("rst_out_score", 64'(out_score), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    check_eq("rst_peak_valid", 64'(peak_valid), 64'd0);
    check_eq("rst_peak_score", 64'(peak_score), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: constant ones, every lag matches fully
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1);
    do_start(8);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b1);
    check_eq("s1_first_beat_valid", 64'(out_valid), 64'd1);
    check_eq("s1_first_beat_lag", 64'(out_lag), 64'd0);
    idle(8);
    do_stop();

    // 2 / 6: PN code, sig delayed by two strobes; lag 2 peaks
    pn_strobes(4, 0);
    do_start(8);
    pn_strobes(8, 0);
    idle(8);
    do_stop();

    // 3: stalled consumer across two period ends
    out_ready = 1'b0;
    do_start(8);
    pn_strobes(8, 0);
    m_push = 1'b0;
    pn_strobes(8, 0);
    m_push = 1'b1;
    check_eq("s3_stall_valid", 64'(out_valid), 64'd1);
    check_eq("s3_stall_lag", 64'(out_lag), 64'd0);
    check_eq("s3_overrun", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    idle(6);
    check_eq("s3_drained", 64'(out_valid), 64'd0);
    pn_strobes(8, 0);
    idle(8);
    do_stop();

    // 4: sparse strobes, stop mid-period, restart
    do_start(8);
    check_eq("s4_overrun_cleared", 64'(overrun), 64'd0);
    for (int i = 0; i < 5; i++) begin
      strobe(1'($urandom_range(0, 1)), lfsr[0]);
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      idle(2);
    end
    do_stop();
    idle(6);
    check_eq("s4_no_partial", 64'(out_valid), 64'd0);
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      strobe(1'($urandom_range(0, 1)), lfsr[0]);
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      idle(2);
    end
    idle(8);
    do_stop();

    // 5: asynchronous reset mid-drain, then zero-period start
    out_ready = 1'b0;
    do_start(8);
    pn_strobes(8, 0);
    m_push = 1'b0;
    pn_strobes(8, 0);
    m_push = 1'b1;
    check_eq("s5_overrun", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("s5_mid_drain_lag", 64'(out_lag), 64'd2);
    rst_n = 1'b0;
    #1;
    check_eq("s5_async_valid", 64'(out_valid), 64'd0);
    check_eq("s5_async_overrun", 64'(overrun), 64'd0);
    check_eq("s5_async_peak_valid", 64'(peak_valid), 64'd0);
    check_eq("s5_async_peak_lag", 64'(peak_lag), 64'd0);
    check_eq("s5_async_peak_score", 64'(peak_score), 64'd0);
    exp_q.delete();
    pk_q.delete();
    m_run = 1'b0;
    for (int k = 0; k < LAGS - 1; k++) m_hist[k] = 1'b0;
    d1 = 1'b0;
    d2 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start(0);
    pn_strobes(12, 0);
    idle(4);
    check_eq("s5_zero_period_idle", 64'(out_valid), 64'd0);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
